// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: state encoding and UART register map shared by the
// uart_tx_sched scheduler and its round-robin arbiter.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_CTRL = 2'd2,
    POLL    = 2'd3
  } state_t;

  localparam logic [31:0] TX_DATA    = 32'h0000_0000;
  localparam logic [31:0] TX_CTRL    = 32'h0000_0004;
  localparam logic [31:0] TX_EN_MASK = 32'h0000_0002;
  localparam int          BUSY_BIT   = 0;

endpackage

// File: rtl/uart_rr_arb2.sv
// uart_rr_arb2: two-way round-robin arbiter. Grants the lone requester, or
// on contention the requester that did not win last time. The last-grant
// register resets to 1 so requester 0 wins the first contention.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last_q;

  // Choose the winner: alternate on contention, otherwise the only requester.
  always_comb begin
    grant_idx = 1'b0;
    if (req[0] && req[1]) begin
      grant_idx = ~last_q;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
    grant = {req[1] & grant_idx, req[0] & ~grant_idx};
  end

  // Remember who won whenever a transfer actually completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: accepts bytes from two requesters (round-robin), writes each
// byte to the UART TX data register, starts transmission via the control
// register, then polls the busy bit until the UART is free again.
// Optional feature macro: UART_TX_SCHED_CRLF_EN -- when defined, an accepted
// 8'h0A is sent as 8'h0D followed by 8'h0A without re-arbitration.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter logic [31:0] UART_BASE_ADDR = 32'h4000_0000,
  parameter int unsigned START_GUARD    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        sched_busy,
  output logic        grant_id
);

  localparam logic [3:0] GUARD_INIT = 4'(START_GUARD);

  state_t     state_q, state_d, poll_next;
  logic [7:0] data_q;
  logic       grant_q;
  logic [3:0] guard_q;
  logic [1:0] arb_grant;
  logic       arb_idx;
  logic       in_idle;
  logic       xfer;
  logic       poll_exit;
  logic [7:0] accept_data;
  logic [7:0] tx_byte;
  logic       unused_rdata;

  uart_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({req1_valid, req0_valid}),
    .advance   (xfer),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Ready is only offered in IDLE and is held low while reset is asserted.
  assign in_idle     = (state_q == IDLE);
  assign req0_ready  = rst_n & in_idle & arb_grant[0];
  assign req1_ready  = rst_n & in_idle & arb_grant[1];
  assign xfer        = req0_ready | req1_ready;
  assign accept_data = arb_idx ? req1_data : req0_data;

  // The guard value seen here is the one for this cycle; the exit fires on
  // the poll cycle in which the guard runs out, so the minimum poll length
  // is exactly START_GUARD cycles.
  assign poll_exit    = (guard_q <= 4'd1) & ~mem_rdata[BUSY_BIT];
  assign unused_rdata = ^mem_rdata[31:1];

  assign sched_busy = ~in_idle;
  assign grant_id   = grant_q;

`ifdef UART_TX_SCHED_CRLF_EN
  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;

  logic cr_pending_q;

  assign tx_byte   = cr_pending_q ? CR_BYTE : data_q;
  assign poll_next = cr_pending_q ? WR_DATA : IDLE;

  // Flag an accepted line feed so a carriage return goes out ahead of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_pending_q <= 1'b0;
    end else if (xfer) begin
      cr_pending_q <= (accept_data == LF_BYTE);
    end else if ((state_q == POLL) && poll_exit) begin
      cr_pending_q <= 1'b0;
    end
  end
`else
  assign tx_byte   = data_q;
  assign poll_next = IDLE;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the accepted byte and owner, and run the post-start guard counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      grant_q <= 1'b0;
      guard_q <= 4'd0;
    end else begin
      if (xfer) begin
        data_q  <= accept_data;
        grant_q <= arb_idx;
      end
      if (state_q == WR_CTRL) begin
        guard_q <= GUARD_INIT;
      end else if ((state_q == POLL) && (guard_q != 4'd0)) begin
        guard_q <= guard_q - 4'd1;
      end
    end
  end

  // Next state and bus outputs; the bus is all-zero unless a strobe is high.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (xfer) state_d = WR_DATA;
      end
      WR_DATA: begin
        mem_we    = 1'b1;
        mem_addr  = UART_BASE_ADDR + TX_DATA;
        mem_wdata = {24'h0, tx_byte};
        state_d   = WR_CTRL;
      end
      WR_CTRL: begin
        mem_we    = 1'b1;
        mem_addr  = UART_BASE_ADDR + TX_CTRL;
        mem_wdata = TX_EN_MASK;
        state_d   = POLL;
      end
      POLL: begin
        mem_re   = 1'b1;
        mem_addr = UART_BASE_ADDR + TX_CTRL;
        if (poll_exit) state_d = poll_next;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched. Stimulus pushes the
// expected UART writes into a queue; a monitor pops and compares on every
// write strobe and checks bus invariants each cycle. A small UART model
// reports busy for a configurable number of poll cycles.
module tb_uart_tx_sched;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] CTRL = 32'h4000_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic        sched_busy, grant_id;
  logic        uart_busy;
  logic [71:0] outs;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        gid;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src0[$];
  logic [7:0] src1[$];
  int         acc_times[$];
  int         poll_lens[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cycle = 0;
  int         poll_cnt = 0;
  int         cur_poll = 0;
  int         busy_len = 0;

  uart_tx_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .sched_busy (sched_busy),
    .grant_id   (grant_id)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // UART model: busy for the first busy_len poll cycles after each start.
  assign uart_busy = mem_re && (poll_cnt <= busy_len);
  assign mem_rdata = {31'h0, uart_busy};
  assign outs = {2'b00, req0_ready, req1_ready, mem_we, mem_re, sched_busy,
                 grant_id, mem_addr, mem_wdata};

  task automatic checkOutput(input string name, input logic [71:0] act,
                             input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic [7:0] b);
`ifdef UART_TX_SCHED_CRLF_EN
    if (b == 8'h0A) begin
      exp_q.push_back('{BASE, 32'h0000_000D, id});
      exp_q.push_back('{CTRL, 32'h0000_0002, id});
    end
`endif
    exp_q.push_back('{BASE, {24'h0, b}, id});
    exp_q.push_back('{CTRL, 32'h0000_0002, id});
    if (id) src1.push_back(b);
    else    src0.push_back(b);
  endtask

  task automatic waitDrain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (src0.size() == 0) &&
             (src1.size() == 0) && !sched_busy;
    end
    checkOutput({name, "_done"}, 72'(done), 72'd1);
    @(negedge clk);
    #1;
  endtask

  // Requester drivers: hold each byte until accepted; scramble data while busy.
  initial begin
    bit hs0, hs1;
    req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00;
    forever begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (hs0 && src0.size() > 0) void'(src0.pop_front());
      if (hs1 && src1.size() > 0) void'(src1.pop_front());
      req0_valid = (src0.size() > 0);
      req1_valid = (src1.size() > 0);
      req0_data  = (src0.size() == 0) ? 8'h00 : (sched_busy ? 8'($urandom) : src0[0]);
      req1_data  = (src1.size() == 0) ? 8'h00 : (sched_busy ? 8'($urandom) : src1[0]);
    end
  end

  // Monitor: scoreboard writes, bus invariants, accept times and poll lengths.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write", {7'h0, grant_id, mem_addr, mem_wdata},
                      {7'h0, e.gid, e.addr, e.data});
        end
      end
      checkOutput("one_ready", 72'(req0_ready & req1_ready), 72'd0);
      checkOutput("we_re_excl", 72'(mem_we & mem_re), 72'd0);
      if (!mem_we && !mem_re) checkOutput("bus_zero", {8'h0, mem_addr, mem_wdata}, 72'd0);
      if (sched_busy) checkOutput("ready_busy", {70'h0, req0_ready, req1_ready}, 72'd0);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_times.push_back(cycle);
      if (mem_re) begin
        cur_poll++;
        poll_cnt++;
      end else begin
        if (cur_poll != 0) poll_lens.push_back(cur_poll);
        cur_poll = 0;
        poll_cnt = 0;
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    bit found;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_values", outs, 72'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", outs, 72'd0);
    #1;

    // Contention: requester 0 wins first, then grants alternate.
    $display("[TB] contention");
    busy_len = 0;
    applyStimulus(1'b0, 8'h10);
    applyStimulus(1'b1, 8'h20);
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b1, 8'h21);
    waitDrain("contention", 200);

    // Single byte 0x41 with UART busy for 10 poll cycles.
    $display("[TB] single byte");
    poll_lens.delete();
    busy_len = 10;
    applyStimulus(1'b0, 8'h41);
    waitDrain("byte41", 200);
    checkOutput("poll_count41", 72'(poll_lens.size()), 72'd1);
    if (poll_lens.size() == 1) checkOutput("poll_len41", 72'(poll_lens[0]), 72'd11);

    // Back-to-back bytes with UART never busy: minimum period.
    $display("[TB] min period");
    poll_lens.delete();
    acc_times.delete();
    busy_len = 0;
    applyStimulus(1'b0, 8'h61);
    applyStimulus(1'b0, 8'h62);
    waitDrain("minperiod", 200);
    checkOutput("accept_count", 72'(acc_times.size()), 72'd2);
    if (acc_times.size() == 2) checkOutput("accept_gap", 72'(acc_times[1] - acc_times[0]), 72'd7);
    checkOutput("poll_count", 72'(poll_lens.size()), 72'd2);
    if (poll_lens.size() == 2) begin
      checkOutput("poll_len_a", 72'(poll_lens[0]), 72'd4);
      checkOutput("poll_len_b", 72'(poll_lens[1]), 72'd4);
    end

    // Reset asserted mid-poll, then requester 1 alone after release.
    $display("[TB] reset in poll");
    busy_len = 1000;
    applyStimulus(1'b0, 8'h77);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      found = mem_re;
    end
    checkOutput("poll_reached", 72'(found), 72'd1);
    #1;
    applyStimulus(1'b1, 8'h99);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_poll", outs, 72'd0);
    busy_len = 0;
    @(negedge clk);
    checkOutput("reset_held", outs, 72'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitDrain("after_reset", 200);

    // Line feed from requester 1 while requester 0 waits.
    $display("[TB] line feed");
    applyStimulus(1'b1, 8'h0A);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      found = sched_busy;
    end
    checkOutput("lf_started", 72'(found), 72'd1);
    applyStimulus(1'b0, 8'h30);
    waitDrain("linefeed", 300);

    checkOutput("scoreboard_empty", 72'(exp_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter UART_BASE_ADDR, default 32'h40000000, base address of the UART register window.
REQ-002 Parameter START_GUARD, default 4, polling cycles that ignore busy=0 after a TX start (range 1..15).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has a byte to send.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-008 req1_valid / req1_data / req1_ready  input 1 / input 8 / output 1  requester 1, same meaning as requester 0.
REQ-009 mem_addr  output  32  UART register address.
REQ-010 mem_wdata  output  32  UART write data.
REQ-011 mem_we  output  1  UART write strobe.
REQ-012 mem_re  output  1  UART read strobe.
REQ-013 mem_rdata  input  32  UART read data, combinational response to mem_re in the same cycle.
REQ-014 sched_busy  output  1  high in every state except IDLE.
REQ-015 grant_id  output  1  requester that owns the byte in flight; valid while sched_busy is high.

Function
REQ-016 FSM states SHALL be IDLE, WR_DATA, WR_CTRL, POLL.
REQ-017 In IDLE: reqN_ready = reqN_valid & granted(N), combinational; a transfer (valid & ready) SHALL latch the data and grant_id, then move to WR_DATA.
REQ-018 Arbitration SHALL be round-robin: when both requests are valid, grant the requester not granted last; when one is valid, grant it.
REQ-019 At most one ready SHALL be high in any cycle; both readys SHALL be 0 outside IDLE.
REQ-020 WR_DATA, one cycle: mem_we=1, mem_addr=UART_BASE_ADDR+0x0, mem_wdata={24'b0,byte}; then go to WR_CTRL.
REQ-021 WR_CTRL, one cycle: mem_we=1, mem_addr=UART_BASE_ADDR+0x4, mem_wdata=32'h2 (TX enable); load the guard counter with START_GUARD; then go to POLL.
REQ-022 POLL: mem_re=1, mem_addr=UART_BASE_ADDR+0x4, guard counter decrements to 0 and saturates there.
REQ-023 POLL exit: when the guard is 0 and mem_rdata[0]==0, go to IDLE; a new byte can be accepted in the cycle after the exit.
REQ-024 When mem_we and mem_re are both 0, mem_addr and mem_wdata SHALL be 0; mem_we and mem_re SHALL never be high together.
REQ-025 Held valid with changing data while not ready SHALL NOT affect the latched byte.
REQ-026 Minimum byte period SHALL be 3+START_GUARD cycles (IDLE accept, WR_DATA, WR_CTRL, POLL).

Reset
REQ-027 Asserting rst_n low at any time, including mid-sequence, SHALL immediately force: state IDLE; mem_we, mem_re and all readys 0; mem_addr and mem_wdata 0; sched_busy 0; grant_id 0; latched byte 0; guard counter 0.
REQ-028 The round-robin last-grant register SHALL reset to 1, so requester 0 wins the first contention.

Configuration
REQ-029 Macro UART_TX_SCHED_CRLF_EN: when defined, an accepted byte 8'h0A SHALL be preceded by a full WR_DATA/WR_CTRL/POLL sequence sending 8'h0D, then the 8'h0A sequence, with no re-arbitration between the two.
REQ-030 When UART_TX_SCHED_CRLF_EN is undefined, every byte SHALL be sent verbatim, and no CR state or logic SHALL be present.

Structure
REQ-031 A shared package SHALL hold: the FSM state encoding; register offsets TX_DATA=0x00 and TX_CTRL=0x04; TX_EN_MASK=32'h2; BUSY_BIT=0.
REQ-032 One sub-module, uart_rr_arb2 (2-way round-robin arbiter, grant plus last-grant register), is natural; the rest is flat.

Verification
REQ-033 req0 sends 0x41, rdata[0] held 1 for 10 cycles then 0 -> WR_DATA writes 0x41 to 0x40000000, WR_CTRL writes 0x2 to 0x40000004, IDLE once busy=0 is seen after the guard.
REQ-034 req0 and req1 both hold valid for 4 bytes -> grants alternate 0,1,0,1; ready is never high for both.
REQ-035 rdata[0]=0 throughout POLL -> exit exactly START_GUARD cycles after entering POLL; next accept 7 cycles after the previous one (default parameters).
REQ-036 rst_n low during POLL -> mem_re drops in the same cycle and all outputs equal their reset values; after release, req1 alone is granted.
REQ-037 CRLF_EN defined, req1 sends 0x0A -> writes 0x0D then 0x0A, with grant_id=1 for both; CRLF_EN undefined -> only 0x0A is written.
